// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and digit/BCD helpers for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_st_e;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble pre-shift correction: +3 on every nibble >= 5.
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake plus segment/anode pins of the display controller.
interface seg_scan_ctrl_if;
  logic        load;
  logic [10:0] value;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output load, value, input busy, an, seg, dp);
  modport slave  (input load, value, output busy, an, seg, dp);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Load handshake and sequential double-dabble: signed 11-bit value -> sign, overflow, 3-digit BCD.
module bin_to_bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [10:0] value,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        sign,
  output logic        ovf,
  output logic        done
);

  conv_st_e    state, nxt;
  logic [9:0]  mag;
  logic [3:0]  cnt;
  logic [11:0] adj;
  logic        ovf_in;
  logic [9:0]  mag_in;

  assign ovf_in = ($signed(value) > 11'sd999) || ($signed(value) < -11'sd999);
  // Only evaluated in range, so the low 10 bits of the negation are the magnitude.
  assign mag_in = ovf_in ? 10'd0 : (value[10] ? (~value[9:0] + 10'd1) : value[9:0]);
  assign adj    = dd_adjust(bcd);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt  = state;
    busy = (state != IDLE);
    done = 1'b0;
    case (state)
      IDLE:    if (load) nxt = SHIFT;
      SHIFT:   if (cnt == 4'd9) nxt = COMMIT;
      COMMIT:  begin done = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcd  <= '0;
      mag  <= '0;
      cnt  <= '0;
      sign <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == IDLE && load) begin
      bcd  <= '0;
      cnt  <= '0;
      mag  <= mag_in;
      sign <= value[10];
      ovf  <= ovf_in;
    end else if (state == SHIFT) begin
      {bcd, mag} <= {adj[10:0], mag, 1'b0};
      cnt        <= cnt + 4'd1;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller: converts a signed distance to BCD and multiplexes it onto the pins.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [11:0]   cv_bcd, disp_bcd;
  logic          cv_sign, cv_ovf, cv_done;
  logic          disp_sign, disp_ovf;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [3:0]    hun, ten, uni;
  logic [6:0]    pat;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bus.load),
    .value (bus.value),
    .busy  (bus.busy),
    .bcd   (cv_bcd),
    .sign  (cv_sign),
    .ovf   (cv_ovf),
    .done  (cv_done)
  );

  // Display state changes only on done so a half-shifted accumulator is never shown.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp_bcd  <= '0;
      disp_sign <= 1'b0;
      disp_ovf  <= 1'b0;
    end else if (cv_done) begin
      disp_bcd  <= cv_bcd;
      disp_sign <= cv_sign;
      disp_ovf  <= cv_ovf;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end

  assign {hun, ten, uni} = disp_bcd;

  always_comb begin
    pat = SEG_BLANK;
    if (disp_ovf) pat = SEG_MINUS;
    else
      case (idx)
        2'd3:    pat = disp_sign ? SEG_MINUS : SEG_BLANK;
        2'd2:    if (hun != 4'd0) pat = seg_of(hun);
        2'd1:    if (hun != 4'd0 || ten != 4'd0) pat = seg_of(ten);
        default: pat = seg_of(uni);
      endcase
  end

  // an and seg share one register stage so the pins switch on the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an_r  <= 4'b1110;
      seg_r <= 7'b1000000;
    end else begin
      an_r  <= ~(4'b0001 << idx);
      seg_r <= pat;
    end

  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4.
module tb_seg_scan_ctrl;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  seg_scan_ctrl_if sif ();

  seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [10:0] v);
    sif.load  = 1'b1;
    sif.value = v;
    tick();
    sif.load  = 1'b0;
  endtask

  // Waits (bounded) for the given anode pattern and returns the seg value shown with it.
  task automatic grab(input logic [3:0] an_want, output logic [6:0] s, output bit ok);
    ok = 1'b0;
    s  = 'x;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sif.an === an_want) begin
        s  = sif.seg;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    int         id;
    sif.load  = 1'b0;
    sif.value = '0;
    rst_n     = 1'b0;
    repeat (2) tick();
    n_tot++; if (sif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", sif.busy); else n_pass++;
    n_tot++; if (sif.an !== 4'b1110) $display("FAIL reset_an got %b want 1110", sif.an); else n_pass++;
    n_tot++; if (sif.seg !== 7'b1000000) $display("FAIL reset_seg got %b want 1000000", sif.seg); else n_pass++;
    n_tot++; if (sif.dp !== 1'b1) $display("FAIL reset_dp got %b want 1", sif.dp); else n_pass++;
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      id      = ((n - 1) / 4) % 4;
      an_exp  = 4'b0001 << id;
      an_exp  = ~an_exp;
      seg_exp = (id == 0) ? 7'b1000000 : BL;
      n_tot++; if (sif.an !== an_exp) $display("FAIL scan_an edge %0d got %b want %b", n, sif.an, an_exp); else n_pass++;
      n_tot++; if (sif.seg !== seg_exp) $display("FAIL scan_seg edge %0d got %b want %b", n, sif.seg, seg_exp); else n_pass++;
    end
  endtask

  task automatic test_convert(input logic [10:0] v, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] ex [4];
    logic [6:0] s;
    logic [3:0] w;
    bit         ok;
    int         c;
    ex[3] = e3; ex[2] = e2; ex[1] = e1; ex[0] = e0;
    do_load(v);
    c = 0;
    while (sif.busy === 1'b1 && c < 30) begin
      c++;
      tick();
    end
    n_tot++; if (c != 11) $display("FAIL busy_len val %0d got %0d want 11", $signed(v), c); else n_pass++;
    for (int d = 3; d >= 0; d--) begin
      w = 4'b0001 << d;
      w = ~w;
      grab(w, s, ok);
      n_tot++;
      if (!ok || s !== ex[d]) $display("FAIL digit%0d val %0d got %b want %b (found=%0d)", d, $signed(v), s, ex[d], ok);
      else n_pass++;
    end
    n_tot++; if (sif.dp !== 1'b1) $display("FAIL dp val %0d got %b want 1", $signed(v), sif.dp); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    logic [6:0] ex [4];
    logic [6:0] s;
    logic [3:0] w;
    bit         ok;
    int         c, hi;
    ex[3] = BL; ex[2] = BL; ex[1] = 7'b1111001; ex[0] = 7'b0100100;
    do_load(11'd12);
    sif.load  = 1'b1;
    sif.value = 11'd99;
    tick();
    sif.load  = 1'b0;
    c = 1;
    while (sif.busy === 1'b1 && c < 30) begin
      c++;
      tick();
    end
    n_tot++; if (c != 11) $display("FAIL busy_len_ign got %0d want 11", c); else n_pass++;
    hi = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (sif.busy !== 1'b0) hi++;
    end
    n_tot++; if (hi != 0) $display("FAIL busy_refire got %0d high cycles want 0", hi); else n_pass++;
    for (int d = 3; d >= 0; d--) begin
      w = 4'b0001 << d;
      w = ~w;
      grab(w, s, ok);
      n_tot++;
      if (!ok || s !== ex[d]) $display("FAIL ign_digit%0d got %b want %b (found=%0d)", d, s, ex[d], ok);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s;
    bit         ok;
    int         c;
    do_load(11'd347);
    c = 1;
    while (sif.busy === 1'b1 && c < 30) begin
      c++;
      tick();
    end
    n_tot++; if (c != 12) $display("FAIL b2b_spacing got %0d want 12", c); else n_pass++;
    do_load(11'(-5));
    n_tot++; if (sif.busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", sif.busy); else n_pass++;
    repeat (12) tick();
    grab(4'b1110, s, ok);
    n_tot++; if (!ok || s !== 7'b0010010) $display("FAIL b2b_units got %b want 0010010", s); else n_pass++;
    grab(4'b0111, s, ok);
    n_tot++; if (!ok || s !== MI) $display("FAIL b2b_sign got %b want %b", s, MI); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    bit         ok;
    int         hi;
    do_load(11'd347);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tot++; if (sif.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", sif.busy); else n_pass++;
    n_tot++; if (sif.an !== 4'b1110) $display("FAIL midrst_an got %b want 1110", sif.an); else n_pass++;
    n_tot++; if (sif.seg !== 7'b1000000) $display("FAIL midrst_seg got %b want 1000000", sif.seg); else n_pass++;
    tick();
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (sif.busy !== 1'b0) hi++;
    end
    n_tot++; if (hi != 0) $display("FAIL midrst_resume got %0d busy cycles want 0", hi); else n_pass++;
    grab(4'b1011, s, ok);
    n_tot++; if (!ok || s !== BL) $display("FAIL midrst_hund got %b want %b", s, BL); else n_pass++;
    grab(4'b0111, s, ok);
    n_tot++; if (!ok || s !== BL) $display("FAIL midrst_sign got %b want %b", s, BL); else n_pass++;
    grab(4'b1110, s, ok);
    n_tot++; if (!ok || s !== 7'b1000000) $display("FAIL midrst_units got %b want 1000000", s); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_convert(11'd347,    BL, 7'b0110000, 7'b0011001, 7'b1111000);
    test_convert(11'(-5),    MI, BL, BL, 7'b0010010);
    test_convert(11'd1000,   MI, MI, MI, MI);
    test_convert(11'(-1024), MI, MI, MI, MI);
    test_convert(11'd999,    BL, 7'b0010000, 7'b0010000, 7'b0010000);
    test_convert(11'(-999),  MI, 7'b0010000, 7'b0010000, 7'b0010000);
    test_convert(11'd105,    BL, 7'b1111001, 7'b1000000, 7'b0010010);
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
